// File: rtl/switch_bounce_gen_if.sv
// Level-command / bouncing-switch bundle between a command source and switch_bounce_gen.
// master = command source, slave = the bounce generator.
interface switch_bounce_gen_if;
  logic i_Level;
  logic o_Switch;
  logic o_Busy;
  logic o_Done;

  modport master (
    output i_Level,
    input  o_Switch,
    input  o_Busy,
    input  o_Done
  );

  modport slave (
    input  i_Level,
    output o_Switch,
    output o_Busy,
    output o_Done
  );
endinterface

// File: rtl/switch_bounce_gen.sv
// Turns a clean level command into a bouncing switch waveform followed by a settle hold.
// Define SWITCH_BOUNCE_GEN_LFSR_EN to randomise edge gaps with a 16-bit Galois LFSR.
module switch_bounce_gen #(
  parameter int unsigned BOUNCE_COUNT  = 3,
  parameter int unsigned MIN_GAP       = 1000,
`ifdef SWITCH_BOUNCE_GEN_LFSR_EN
  parameter logic [15:0] GAP_MASK      = 16'h0FFF,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
`endif
  parameter int unsigned SETTLE_CYCLES = 250000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  switch_bounce_gen_if.slave sw_if
);

`ifdef SWITCH_BOUNCE_GEN_LFSR_EN
  localparam int unsigned GAP_MAX = MIN_GAP + 32'(GAP_MASK);
`else
  localparam int unsigned GAP_MAX = MIN_GAP;
`endif
  localparam int unsigned GAP_W      = ($clog2(GAP_MAX + 1) > 1) ? $clog2(GAP_MAX + 1) : 1;
  localparam int unsigned REM_W      = ($clog2(BOUNCE_COUNT + 1) > 1) ? $clog2(BOUNCE_COUNT + 1) : 1;
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned HOLD_W     = ($clog2(SETTLE_EFF + 1) > 1) ? $clog2(SETTLE_EFF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e             state_q,  state_d;
  logic               level_q;
  logic               target_q, target_d;
  logic               switch_q, switch_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [REM_W-1:0]   rem_q,    rem_d;
  logic [GAP_W-1:0]   gap_q,    gap_d;
  logic [HOLD_W-1:0]  hold_q,   hold_d;
  logic [GAP_W-1:0]   gap_load_c;

`ifdef SWITCH_BOUNCE_GEN_LFSR_EN
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; free-runs in every state.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign gap_load_c = GAP_W'(MIN_GAP + 32'(lfsr_q & GAP_MASK));
`else
  assign gap_load_c = GAP_W'(MIN_GAP);
`endif

  // level_q samples the command; IDLE compares the sampled copy, so the output
  // edge lands one clock after the change is sampled.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      level_q  <= 1'b0;
      target_q <= 1'b0;
      switch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rem_q    <= '0;
      gap_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= sw_if.i_Level;
      target_q <= target_d;
      switch_q <= switch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    switch_d = switch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rem_d    = rem_q;
    gap_d    = gap_q;
    hold_d   = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (level_q != target_q) begin
          target_d = level_q;
          switch_d = level_q;
          rem_d    = REM_W'(BOUNCE_COUNT);
          gap_d    = gap_load_c;
          busy_d   = 1'b1;
          state_d  = ST_BOUNCE;
        end
      end

      // gap_q counts down to the next output edge; the edge fires on the count of 1.
      ST_BOUNCE: begin
        if (gap_q <= GAP_W'(1)) begin
          if (rem_q != '0) begin
            switch_d = ~switch_q;
            rem_d    = rem_q - REM_W'(1);
            gap_d    = gap_load_c;
          end else begin
            switch_d = target_q;
            gap_d    = '0;
            hold_d   = HOLD_W'(SETTLE_EFF);
            state_d  = ST_SETTLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_SETTLE: begin
        if (hold_q <= HOLD_W'(1)) begin
          hold_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sw_if.o_Switch = switch_q;
  assign sw_if.o_Busy   = busy_q;
  assign sw_if.o_Done   = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Scoreboard bench for switch_bounce_gen: stimulus queues expected switch edges and
// done pulses with their clock numbers; per-DUT monitors pop and compare them.
module tb_switch_bounce_gen;

  typedef struct {
    int cyc;
    bit done;
    bit val;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   prev3 = 1'b0;
  bit   prev0 = 1'b0;
  ev_t  q3[$];
  ev_t  q0[$];

  switch_bounce_gen_if if3 ();
  switch_bounce_gen_if if0 ();

  switch_bounce_gen #(
    .BOUNCE_COUNT (3),
    .MIN_GAP      (4),
    .SETTLE_CYCLES(8)
  ) dut3 (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .sw_if  (if3)
  );

  switch_bounce_gen #(
    .BOUNCE_COUNT (0),
    .MIN_GAP      (4),
    .SETTLE_CYCLES(8)
  ) dut0 (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .sw_if  (if0)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; read on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t ev(input int c, input bit d, input bit v);
    ev_t e;
    e.cyc  = c;
    e.done = d;
    e.val  = v;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_ev(input string tag, input bit have, input ev_t exp,
                        input bit is_done, input bit val);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s unexpected event: got cyc=%0d done=%0b val=%0b, want no event",
               tag, cyc, is_done, val);
    end else if (exp.cyc != cyc || exp.done != is_done || exp.val != val) begin
      bad++;
      $display("FAIL %s event: got cyc=%0d done=%0b val=%0b, want cyc=%0d done=%0b val=%0b",
               tag, cyc, is_done, val, exp.cyc, exp.done, exp.val);
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon3
    ev_t e;
    bit  have;
    if (mon_en) begin
      if (if3.o_Switch !== prev3) begin
        have = (q3.size() > 0);
        if (have) e = q3.pop_front(); else e = ev(0, 1'b0, 1'b0);
        cmp_ev("dut3 switch", have, e, 1'b0, if3.o_Switch);
        prev3 = if3.o_Switch;
      end
      if (if3.o_Done === 1'b1) begin
        have = (q3.size() > 0);
        if (have) e = q3.pop_front(); else e = ev(0, 1'b0, 1'b0);
        cmp_ev("dut3 done", have, e, 1'b1, 1'b1);
      end
    end
  end

  always @(negedge clk) begin : mon0
    ev_t e;
    bit  have;
    if (mon_en) begin
      if (if0.o_Switch !== prev0) begin
        have = (q0.size() > 0);
        if (have) e = q0.pop_front(); else e = ev(0, 1'b0, 1'b0);
        cmp_ev("dut0 switch", have, e, 1'b0, if0.o_Switch);
        prev0 = if0.o_Switch;
      end
      if (if0.o_Done === 1'b1) begin
        have = (q0.size() > 0);
        if (have) e = q0.pop_front(); else e = ev(0, 1'b0, 1'b0);
        cmp_ev("dut0 done", have, e, 1'b1, 1'b1);
      end
    end
  end

  initial begin : stim
    int b;
    int r;
    if3.i_Level = 1'b0;
    if0.i_Level = 1'b0;

    // Reset values, then 100 quiet clocks.
    wait_until(3);
    rst_n = 1'b1;
    wait_until(4);
    chk("rst dut3 switch", if3.o_Switch, 0);
    chk("rst dut3 busy",   if3.o_Busy,   0);
    chk("rst dut3 done",   if3.o_Done,   0);
    chk("rst dut0 switch", if0.o_Switch, 0);
    chk("rst dut0 busy",   if0.o_Busy,   0);
    chk("rst dut0 done",   if0.o_Done,   0);
    mon_en = 1'b1;
    wait_until(104);

    // Rising command: 3 bounces, 8-clock settle.
    b = 114;
    wait_until(b - 1);
    if3.i_Level = 1'b1;
    q3.push_back(ev(b + 1,  1'b0, 1'b1));
    q3.push_back(ev(b + 5,  1'b0, 1'b0));
    q3.push_back(ev(b + 9,  1'b0, 1'b1));
    q3.push_back(ev(b + 13, 1'b0, 1'b0));
    q3.push_back(ev(b + 17, 1'b0, 1'b1));
    q3.push_back(ev(b + 25, 1'b1, 1'b1));
    wait_until(b);
    chk("s2 busy before", if3.o_Busy, 0);
    wait_until(b + 1);
    chk("s2 busy first edge", if3.o_Busy, 1);
    wait_until(b + 24);
    chk("s2 busy last settle", if3.o_Busy, 1);
    wait_until(b + 25);
    chk("s2 busy at done", if3.o_Busy, 0);
    wait_until(b + 39);

    // Falling command with level wiggles ignored, then a held change restarts after done.
    b = b + 40;
    wait_until(b - 1);
    if3.i_Level = 1'b0;
    q3.push_back(ev(b + 1,  1'b0, 1'b0));
    q3.push_back(ev(b + 5,  1'b0, 1'b1));
    q3.push_back(ev(b + 9,  1'b0, 1'b0));
    q3.push_back(ev(b + 13, 1'b0, 1'b1));
    q3.push_back(ev(b + 17, 1'b0, 1'b0));
    q3.push_back(ev(b + 25, 1'b1, 1'b1));
    q3.push_back(ev(b + 26, 1'b0, 1'b1));
    q3.push_back(ev(b + 30, 1'b0, 1'b0));
    q3.push_back(ev(b + 34, 1'b0, 1'b1));
    q3.push_back(ev(b + 38, 1'b0, 1'b0));
    q3.push_back(ev(b + 42, 1'b0, 1'b1));
    q3.push_back(ev(b + 50, 1'b1, 1'b1));
    wait_until(b + 5);
    if3.i_Level = 1'b1;
    wait_until(b + 9);
    if3.i_Level = 1'b0;
    wait_until(b + 13);
    if3.i_Level = 1'b1;
    wait_until(b + 59);

    // Reset in the middle of a sequence: outputs clear at once, no done.
    b = b + 60;
    wait_until(b - 1);
    if3.i_Level = 1'b0;
    q3.push_back(ev(b + 1, 1'b0, 1'b0));
    q3.push_back(ev(b + 5, 1'b0, 1'b1));
    q3.push_back(ev(b + 7, 1'b0, 1'b0));
    wait_until(b + 6);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst switch", if3.o_Switch, 0);
    chk("midrst busy",   if3.o_Busy,   0);
    chk("midrst done",   if3.o_Done,   0);
    if3.i_Level = 1'b1;
    r = b + 9;
    q3.push_back(ev(r + 2,  1'b0, 1'b1));
    q3.push_back(ev(r + 6,  1'b0, 1'b0));
    q3.push_back(ev(r + 10, 1'b0, 1'b1));
    q3.push_back(ev(r + 14, 1'b0, 1'b0));
    q3.push_back(ev(r + 18, 1'b0, 1'b1));
    q3.push_back(ev(r + 26, 1'b1, 1'b1));
    wait_until(r);
    rst_n = 1'b1;
    wait_until(r + 39);

    // No-bounce instance: single clean edge, done 12 clocks later.
    b = r + 40;
    wait_until(b - 1);
    if0.i_Level = 1'b1;
    q0.push_back(ev(b + 1,  1'b0, 1'b1));
    q0.push_back(ev(b + 13, 1'b1, 1'b1));
    wait_until(b + 19);
    b = b + 20;
    wait_until(b - 1);
    if0.i_Level = 1'b0;
    q0.push_back(ev(b + 1,  1'b0, 1'b0));
    q0.push_back(ev(b + 13, 1'b1, 1'b1));
    wait_until(b + 12);
    chk("s4 busy last settle", if0.o_Busy, 1);
    wait_until(b + 13);
    chk("s4 busy at done", if0.o_Busy, 0);
    wait_until(b + 30);

    chk("dut3 events left", q3.size(), 0);
    chk("dut0 events left", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
